owr_presence_scan: RTL and testbench

- Multi-channel 1-wire presence scanner with its own reset/presence-pulse timing engine; needs no external 1-wire master core.
- Polls OWN independent 1-wire buses round-robin, one reset/presence slot per channel per scan.
- Filters results and keeps a stable presence bitmap plus a shorted-bus fault bitmap.
- Sits between the board pins (open-drain pull-down enables) and LED/status logic or a CPU status register.

---
 rtl/owr_pkg.sv | 33 +++
 rtl/owr_us_tick.sv | 29 ++
 rtl/owr_presence_scan.sv | 199 +++++++++++++++++++
 tb/tb_owr_presence_scan.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/owr_pkg.sv
// Shared types, default 1-wire timings and constant helpers for the presence scanner.
package owr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRstLow,
    StWaitSmp,
    StSample,
    StRec,
    StNext
  } owr_state_e;

  localparam int unsigned OwrTRstUs = 480;
  localparam int unsigned OwrTSmpUs = 70;
  localparam int unsigned OwrTRecUs = 410;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned owr_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // A zero-length duration still takes one tick.
  function automatic int unsigned owr_ticks(input int unsigned us);
    return (us == 0) ? 1 : us;
  endfunction

endpackage

// File: rtl/owr_us_tick.sv
// Free-running prescaler: one-cycle tick every CDR clocks (one per microsecond).
module owr_us_tick
  import owr_pkg::*;
#(
  parameter int unsigned CDR = 48
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CW = owr_clog2(CDR);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CW'(CDR - 1));
    cnt_d  = o_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/owr_presence_scan.sv
// Round-robin 1-wire reset/presence scanner with per-channel result filtering
// and shorted-bus detection.
module owr_presence_scan
  import owr_pkg::*;
#(
  parameter int unsigned OWN       = 4,
  parameter int unsigned CDR       = 48,
  parameter int unsigned T_RST_US  = OwrTRstUs,
  parameter int unsigned T_SMP_US  = OwrTSmpUs,
  parameter int unsigned T_REC_US  = OwrTRecUs,
  parameter int unsigned T_IDLE_US = 20000,
  parameter int unsigned FILT      = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic           i_scan_now,
  input  logic [OWN-1:0] i_owr,
  output logic [OWN-1:0] o_owr_e,
  output logic [OWN-1:0] o_present,
  output logic [OWN-1:0] o_fault,
  output logic [OWN-1:0] o_change,
  output logic           o_scan_done,
  output logic           o_busy
);

  localparam int unsigned TRst  = owr_ticks(T_RST_US);
  localparam int unsigned TSmp  = owr_ticks(T_SMP_US);
  localparam int unsigned TRec  = owr_ticks(T_REC_US);
  localparam int unsigned TIdle = owr_ticks(T_IDLE_US);
  localparam int unsigned TMaxA = (TRst > TSmp) ? TRst : TSmp;
  localparam int unsigned TMaxB = (TRec > TIdle) ? TRec : TIdle;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned TW    = owr_clog2(TMax) + 1;
  localparam int unsigned CHW   = owr_clog2(OWN);
  localparam int unsigned FW    = owr_clog2(FILT + 1);

  owr_state_e state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [OWN-1:0] present_q, present_d;
  logic [OWN-1:0] fault_q, fault_d;
  logic [OWN-1:0] mask_q, mask_d;
  logic [OWN-1:0] change_q, change_d;
  logic [OWN-1:0][FW-1:0] fcnt_q, fcnt_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic tick;
  logic tmr_last;
  logic result;

  owr_us_tick #(
    .CDR(CDR)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (tick)
  );

  assign tmr_last = (tmr_q == TW'(1));

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tmr_d     = tmr_q;
    idle_d    = idle_q;
    present_d = present_q;
    fault_d   = fault_q;
    mask_d    = mask_q;
    fcnt_d    = fcnt_q;
    busy_d    = busy_q;
    change_d  = '0;
    done_d    = 1'b0;
    result    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_scan_now || (i_en && idle_q == '0)) begin
          state_d = StCheck;
          ch_d    = '0;
          idle_d  = TW'(TIdle);
          busy_d  = 1'b1;
        end else if (i_en && tick && idle_q != '0) begin
          idle_d = idle_q - TW'(1);
        end
      end
      // A bus already low before we drive it is shorted or stuck.
      StCheck: begin
        if (tick) begin
          if (!i_owr[ch_q]) begin
            fault_d[ch_q] = 1'b1;
            state_d       = StNext;
          end else begin
            fault_d[ch_q] = 1'b0;
            state_d       = StRstLow;
            tmr_d         = TW'(TRst);
          end
        end
      end
      StRstLow: begin
        if (tick) begin
          if (tmr_last) begin
            state_d = StWaitSmp;
            tmr_d   = TW'(TSmp);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      StWaitSmp: begin
        if (tick) begin
          if (tmr_last) begin
            state_d = StSample;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      StSample: begin
        result  = ~i_owr[ch_q];
        state_d = StRec;
        tmr_d   = TW'(TRec);
        if (result == present_q[ch_q]) begin
          fcnt_d[ch_q] = '0;
        end else if (fcnt_q[ch_q] == FW'(FILT - 1)) begin
          present_d[ch_q] = result;
          fcnt_d[ch_q]    = '0;
          mask_d[ch_q]    = 1'b1;
        end else begin
          fcnt_d[ch_q] = fcnt_q[ch_q] + FW'(1);
        end
      end
      StRec: begin
        if (tick) begin
          if (tmr_last) begin
            state_d = StNext;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      StNext: begin
        if (ch_q == CHW'(OWN - 1)) begin
          done_d   = 1'b1;
          change_d = mask_q;
          mask_d   = '0;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = StCheck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded from state so the async reset releases the bus without a clock.
  always_comb begin
    o_owr_e = '0;
    if (state_q == StRstLow) o_owr_e[ch_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      tmr_q     <= '0;
      idle_q    <= TW'(TIdle);
      present_q <= '0;
      fault_q   <= '0;
      mask_q    <= '0;
      change_q  <= '0;
      fcnt_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tmr_q     <= tmr_d;
      idle_q    <= idle_d;
      present_q <= present_d;
      fault_q   <= fault_d;
      mask_q    <= mask_d;
      change_q  <= change_d;
      fcnt_q    <= fcnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign o_present   = present_q;
  assign o_fault     = fault_q;
  assign o_change    = change_q;
  assign o_scan_done = done_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_owr_presence_scan.sv
// Bench for owr_presence_scan: device models on each bus, scan-level reference
// model checked every cycle, plus literal expectations for the directed scans.
module tb_owr_presence_scan;

  localparam int unsigned OWN   = 2;
  localparam int unsigned CDR   = 4;
  localparam int unsigned FILT  = 2;
  localparam int unsigned TIDLE = 100;
  localparam int unsigned TRST  = 480;
  localparam int          CLK_PER = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic scan_now = 1'b0;
  logic [OWN-1:0] dev = '0;
  logic [OWN-1:0] stuck = '0;
  wire  [OWN-1:0] owr;
  logic [OWN-1:0] owr_e, present, fault, change;
  logic scan_done, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int e_starts = 0;

  owr_presence_scan #(
    .OWN(OWN), .CDR(CDR), .T_RST_US(TRST), .T_SMP_US(70), .T_REC_US(410),
    .T_IDLE_US(TIDLE), .FILT(FILT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_scan_now (scan_now),
    .i_owr      (owr),
    .o_owr_e    (owr_e),
    .o_present  (present),
    .o_fault    (fault),
    .o_change   (change),
    .o_scan_done(scan_done),
    .o_busy     (busy)
  );

  always #(CLK_PER / 2) clk = ~clk;

  // Open-drain bus: low if master drives, device answers, or bus is shorted.
  for (genvar g = 0; g < OWN; g++) begin : g_dev
    logic pull = 1'b0;
    assign owr[g] = ~(owr_e[g] | pull | stuck[g]);
    initial forever begin
      @(negedge owr_e[g]);
      if (dev[g] && rst_n) begin
        #(CLK_PER * CDR * $urandom_range(60, 15));
        pull = 1'b1;
        #(CLK_PER * CDR * $urandom_range(240, 60));
        pull = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d..%0d at %0t", name, val, lo, hi, $time);
    end
  endtask

  // Scan-level reference: per-channel result, fault and filter from the rules.
  logic [OWN-1:0] m_present = '0, m_fault = '0, flips = '0, seen_e = '0;
  logic [OWN-1:0] snap_dev = '0, snap_stuck = '0, prev_present = '0, prev_e = '0;
  logic busy_prev = 1'b0, done_prev = 1'b0;
  int   m_cnt [OWN];
  int   e_start_cyc [OWN];
  int   cyc = 0;

  initial forever begin
    logic [OWN-1:0] exp_chg;
    logic [OWN-1:0] exp_seen;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {owr_e, present, fault, change, scan_done, busy}, '0);
      m_present = '0; m_fault = '0; flips = '0; seen_e = '0;
      prev_present = '0; prev_e = '0; busy_prev = 1'b0; done_prev = 1'b0;
      for (int c = 0; c < OWN; c++) m_cnt[c] = 0;
    end else begin
      chk("owr_e_at_most_one", $countones(owr_e) <= 1, 1);
      chk("owr_e_only_busy", busy || owr_e == '0, 1);
      if (done_prev) chk("done_single_cycle", scan_done, 0);
      if (busy && !busy_prev) begin
        n_starts++;
        snap_dev = dev;
        snap_stuck = stuck;
        seen_e = '0;
      end
      for (int c = 0; c < OWN; c++) begin
        if (owr_e[c] && !prev_e[c]) begin
          e_start_cyc[c] = cyc;
          seen_e[c] = 1'b1;
        end
        if (!owr_e[c] && prev_e[c])
          chk_range("owr_e_low_len", cyc - e_start_cyc[c], (TRST - 1) * CDR + 1, TRST * CDR);
      end
      flips |= present ^ prev_present;
      if (scan_done) begin
        exp_chg = '0;
        for (int c = 0; c < OWN; c++) begin
          if (snap_stuck[c]) begin
            m_fault[c] = 1'b1;
          end else begin
            m_fault[c] = 1'b0;
            if (snap_dev[c] == m_present[c]) begin
              m_cnt[c] = 0;
            end else begin
              m_cnt[c]++;
              if (m_cnt[c] == FILT) begin
                m_present[c] = ~m_present[c];
                m_cnt[c] = 0;
                exp_chg[c] = 1'b1;
              end
            end
          end
        end
        exp_seen = ~snap_stuck;
        chk("scan_present", present, m_present);
        chk("scan_fault", fault, m_fault);
        chk("scan_change", change, exp_chg);
        chk("change_subset", (change & ~flips) == '0, 1);
        chk("owr_e_channels", seen_e, exp_seen);
        chk("done_not_busy", busy, 0);
        flips = '0;
      end else begin
        chk("change_outside_done", change, '0);
        if (!busy) begin
          chk("idle_present", present, m_present);
          chk("idle_fault", fault, m_fault);
        end
      end
      prev_present = present;
      prev_e = owr_e;
      busy_prev = busy;
      done_prev = scan_done;
    end
  end

  task automatic pulse_scan();
    @(negedge clk);
    scan_now = 1'b1;
    e_starts++;
    @(negedge clk);
    scan_now = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12000 && !ok; i++) begin
      @(negedge clk);
      ok = scan_done;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int lat;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owr_e", owr_e, 0);
    chk("rst_present", present, 0);
    rst_n = 1'b1;

    // Device on ch0, FILT=2: first scan does not flip; scan_now mid-scan ignored.
    dev = 2'b01;
    pulse_scan();
    repeat (100) @(negedge clk);
    chk("busy_mid_scan", busy, 1);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    wait_done("scan1_done");
    chk("scan1_present", present, 2'b00);
    chk("scan1_change", change, 2'b00);
    repeat (300) @(negedge clk);
    chk("no_extra_scan", n_starts, e_starts);

    pulse_scan();
    wait_done("scan2_done");
    chk("scan2_present", present, 2'b01);
    chk("scan2_change", change, 2'b01);

    // Device absent for one scan only: filter holds the bit.
    dev = 2'b00;
    pulse_scan();
    wait_done("scan3_done");
    chk("scan3_present", present, 2'b01);
    chk("scan3_change", change, 2'b00);
    dev = 2'b01;

    // Shorted ch1 flags a fault and is never driven.
    stuck = 2'b10;
    pulse_scan();
    wait_done("scan4_done");
    chk("scan4_fault", fault, 2'b10);
    chk("scan4_present", present, 2'b01);
    stuck = 2'b00;
    pulse_scan();
    wait_done("scan5_done");
    chk("scan5_fault", fault, 2'b00);

    for (int k = 0; k < 2; k++) begin
      dev = OWN'($urandom);
      stuck = OWN'($urandom & $urandom);
      pulse_scan();
      wait_done("rand_scan_done");
    end
    stuck = '0;
    dev = 2'b01;

    // Reset during RST_LOW must release the bus without a clock edge.
    pulse_scan();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = (owr_e != '0);
    end
    chk("reached_rst_low", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_owr_e", owr_e, 0);
    chk("async_outputs", {present, fault, change, scan_done, busy}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("no_scan_after_reset", n_starts, e_starts);

    // Automatic scanning from reset with a 100 us idle period.
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (!busy && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    e_starts++;
    chk_range("auto_first_start", lat, (TIDLE - 1) * CDR, TIDLE * CDR + 3);
    wait_done("auto1_done");
    lat = 0;
    while (!busy && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    e_starts++;
    chk_range("auto_idle_gap", lat, (TIDLE - 1) * CDR, TIDLE * CDR + 3);
    en = 1'b0;
    wait_done("auto2_done_after_disable");
    repeat (600) @(negedge clk);
    chk("scan_count_end", n_starts, e_starts);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
